// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-lite memory slave: response codes, FSM states and
// the data-width-to-strobe-width helper.
package axi_lite_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_EXEC,
      W_RESP
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_EXEC,
      R_DATA
   } rd_state_t;

   function automatic int unsigned strb_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/axi_lite_mem_array.sv
// Word memory split into byte lanes: per-byte write enables and one registered
// read port that returns the pre-write word when read and write collide.
module axi_lite_mem_array
   import axi_lite_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned DEPTH  = 256,
   localparam int unsigned STRB_W = strb_width(DATA_W),
   localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [STRB_W-1:0] wr_strb_i,
   input  logic              rd_en_i,
   input  logic              rd_zero_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [DATA_W-1:0] rd_data_o
);

   for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_q [DEPTH] = '{default: '0};
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
         if (wr_en_i && wr_strb_i[gi]) begin
            lane_q[wr_idx_i] <= wr_data_i[gi*8 +: 8];
         end
      end

      // Only the output register is reset; the array contents survive rst.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_q <= '0;
         end else if (rd_en_i) begin
            rd_q <= rd_zero_i ? 8'h00 : lane_q[rd_idx_i];
         end
      end

      assign rd_data_o[gi*8 +: 8] = rd_q;
   end

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI-lite slave in front of a word-addressed memory: independent AW/W capture,
// B and R response channels, decode errors and registered ready/valid outputs.
module axi_lite_slave_mem
   import axi_lite_pkg::*;
#(
   parameter  int unsigned     ADDR_W    = 32,
   parameter  int unsigned     DATA_W    = 32,
   parameter  int unsigned     DEPTH     = 256,
   parameter  longint unsigned BASE_ADDR = 0,
   localparam int unsigned     STRB_W    = strb_width(DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic              write_addr_valid,
   output logic              write_addr_ready,
   input  logic [DATA_W-1:0] write_data,
   input  logic [STRB_W-1:0] write_strb,
   input  logic              write_data_valid,
   output logic              write_data_ready,
   output logic [1:0]        write_resp,
   output logic              write_resp_valid,
   input  logic              write_resp_ready,
   input  logic [ADDR_W-1:0] read_addr,
   input  logic              read_addr_valid,
   output logic              read_addr_ready,
   output logic [DATA_W-1:0] read_data,
   output logic [1:0]        read_resp,
   output logic              read_data_valid,
   input  logic              read_data_ready
);

   localparam int unsigned       OFF_W  = $clog2(STRB_W);
   localparam int unsigned       IDX_W  = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

   // In range when the offset from BASE fits in IDX_W word bits plus the byte offset.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - BASE_A;
      return (a >= BASE_A) && ((off >> (OFF_W + IDX_W)) == '0);
   endfunction

   wr_state_t         wr_state_q, wr_state_d;
   logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic              aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
   logic              b_valid_q, b_valid_d;
   resp_t             b_resp_q, b_resp_d;
   logic [ADDR_W-1:0] aw_addr_q;
   logic [DATA_W-1:0] w_data_q;
   logic [STRB_W-1:0] w_strb_q;
   logic              aw_fire, w_fire, wr_ok, mem_we;

   rd_state_t         rd_state_q, rd_state_d;
   logic              ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
   resp_t             r_resp_q, r_resp_d;
   logic [ADDR_W-1:0] ar_addr_q;
   logic              ar_fire, rd_ok, mem_re;

   assign aw_fire = aw_ready_q & write_addr_valid;
   assign w_fire  = w_ready_q & write_data_valid;
   assign wr_ok   = in_range(aw_addr_q);
   assign mem_we  = (wr_state_q == W_EXEC) && wr_ok;

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      b_valid_d  = b_valid_q;
      b_resp_d   = b_resp_q;
      case (wr_state_q)
         W_IDLE: begin
            aw_held_d = aw_held_q | aw_fire;
            w_held_d  = w_held_q | w_fire;
            if (aw_held_d && w_held_d) begin
               wr_state_d = W_EXEC;
            end
         end
         W_EXEC: begin
            wr_state_d = W_RESP;
            b_valid_d  = 1'b1;
            b_resp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
         end
         W_RESP: begin
            if (write_resp_ready) begin
               wr_state_d = W_IDLE;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               b_valid_d  = 1'b0;
               b_resp_d   = RESP_OKAY;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
      aw_ready_d = (wr_state_d == W_IDLE) && !aw_held_d;
      w_ready_d  = (wr_state_d == W_IDLE) && !w_held_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_state_q <= W_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         b_resp_q   <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         aw_ready_q <= aw_ready_d;
         w_ready_q  <= w_ready_d;
         b_valid_q  <= b_valid_d;
         b_resp_q   <= b_resp_d;
      end
   end

   // Holding registers carry no reset; the held flags qualify them.
   always_ff @(posedge clk) begin
      if (aw_fire) aw_addr_q <= write_addr;
      if (w_fire) begin
         w_data_q <= write_data;
         w_strb_q <= write_strb;
      end
      if (ar_fire) ar_addr_q <= read_addr;
   end

   assign ar_fire = ar_ready_q & read_addr_valid;
   assign rd_ok   = in_range(ar_addr_q);
   assign mem_re  = (rd_state_q == R_EXEC);

   always_comb begin
      rd_state_d = rd_state_q;
      r_valid_d  = r_valid_q;
      r_resp_d   = r_resp_q;
      case (rd_state_q)
         R_IDLE: begin
            if (ar_fire) rd_state_d = R_EXEC;
         end
         R_EXEC: begin
            rd_state_d = R_DATA;
            r_valid_d  = 1'b1;
            r_resp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
         end
         R_DATA: begin
            if (read_data_ready) begin
               rd_state_d = R_IDLE;
               r_valid_d  = 1'b0;
               r_resp_d   = RESP_OKAY;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
      ar_ready_d = (rd_state_d == R_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_state_q <= R_IDLE;
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_resp_q   <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         ar_ready_q <= ar_ready_d;
         r_valid_q  <= r_valid_d;
         r_resp_q   <= r_resp_d;
      end
   end

   axi_lite_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (mem_we),
      .wr_idx_i  (IDX_W'((aw_addr_q - BASE_A) >> OFF_W)),
      .wr_data_i (w_data_q),
      .wr_strb_i (w_strb_q),
      .rd_en_i   (mem_re),
      .rd_zero_i (!rd_ok),
      .rd_idx_i  (IDX_W'((ar_addr_q - BASE_A) >> OFF_W)),
      .rd_data_o (read_data)
   );

   assign write_addr_ready = aw_ready_q;
   assign write_data_ready = w_ready_q;
   assign write_resp       = b_resp_q;
   assign write_resp_valid = b_valid_q;
   assign read_addr_ready  = ar_ready_q;
   assign read_resp        = r_resp_q;
   assign read_data_valid  = r_valid_q;

endmodule
